// File: rtl/text_console_pkg.sv
// Shared character codes and FSM encoding for the text console buffer.
package text_console_pkg;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] PRINT_MIN  = 8'h20;
  localparam logic [7:0] PRINT_MAX  = 8'h7E;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CLEAR_ROW = 2'd1;
  localparam logic [1:0] ST_CLEAR_ALL = 2'd2;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_MIN) && (b <= PRINT_MAX);
  endfunction
endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: synchronous write, synchronous read-first read.
module text_ram #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_q
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end
endmodule

// File: rtl/text_console_buffer.sv
// Byte-stream text console: cursor/clear FSM, scrolling row map and renderer read port.
module text_console_buffer
  import text_console_pkg::*;
#(
  parameter int COLS  = 32,
  parameter int ROWS  = 4,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             mode_scroll,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic [7:0]       rd_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             overrun
);
  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = $clog2(CELLS);

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ROW_W-1:0]  clr_row;
  logic [ROW_W-1:0]  top;
  logic [ROW_W-1:0]  cur_phys;
  logic [ROW_W-1:0]  next_top;
  logic              accept;
  logic              last_col;
  logic              last_row;
  logic              newline;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic              rd_oor_p0;
  logic              rd_blank_p1;
  logic [7:0]        ram_q_p1;

  // Modular add without relying on power-of-two wraparound.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] l,
                                               input logic [ROW_W-1:0] t);
    logic [ROW_W:0] s;
    s = {1'b0, l} + {1'b0, t};
    if (s >= (ROW_W+1)'(ROWS)) s = s - (ROW_W+1)'(ROWS);
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
    return ADDR_W'(int'(r) * COLS + int'(c));
  endfunction

  assign rx_ready = (state == ST_IDLE);
  assign accept   = rx_valid && rx_ready;
  assign cur_phys = phys_row(cur_row, top);
  assign last_col = (cur_col == COL_W'(COLS-1));
  assign last_row = (cur_row == ROW_W'(ROWS-1));
  assign newline  = (rx_data == CHAR_LF) || (is_printable(rx_data) && last_col);
  assign next_top = (top == ROW_W'(ROWS-1)) ? '0 : top + ROW_W'(1);

  always_comb begin
    we      = 1'b0;
    wr_addr = '0;
    wr_data = CHAR_SPACE;
    case (state)
      ST_CLEAR_ALL: begin
        we      = 1'b1;
        wr_addr = clr_cnt;
      end
      ST_CLEAR_ROW: begin
        we      = 1'b1;
        wr_addr = cell_addr(clr_row, clr_cnt[COL_W-1:0]);
      end
      default: begin
        if (accept) begin
          if (is_printable(rx_data)) begin
            we      = 1'b1;
            wr_addr = cell_addr(cur_phys, cur_col);
            wr_data = rx_data;
          end else if ((rx_data == CHAR_BS) && (cur_col != '0)) begin
            we      = 1'b1;
            wr_addr = cell_addr(cur_phys, cur_col - COL_W'(1));
          end
        end
      end
    endcase
  end

  // Read stage p0: map logical row through top and flag out-of-range coordinates.
  assign rd_oor_p0  = ({1'b0, rd_row} >= (ROW_W+1)'(ROWS)) ||
                      ({1'b0, rd_col} >= (COL_W+1)'(COLS));
  assign rd_addr_p0 = cell_addr(phys_row(rd_row, top), rd_col);

  text_ram #(.DEPTH(CELLS), .ADDR_W(ADDR_W)) u_ram (
    .clk    (clk),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr_p0),
    .rd_q   (ram_q_p1)
  );

  // Read stage p1: RAM output, blanked for out-of-range or straight after reset.
  assign rd_data = rd_blank_p1 ? 8'h00 : ram_q_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_CLEAR_ALL;
      clr_cnt     <= '0;
      clr_row     <= '0;
      top         <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
      overrun     <= 1'b0;
      rd_blank_p1 <= 1'b1;
    end else begin
      rd_blank_p1 <= rd_oor_p0;
      if (rx_valid && !rx_ready) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (rx_data == CHAR_FF) begin
              state   <= ST_CLEAR_ALL;
              clr_cnt <= '0;
              top     <= '0;
              cur_row <= '0;
              cur_col <= '0;
            end else if (rx_data == CHAR_CR) begin
              cur_col <= '0;
            end else if (rx_data == CHAR_BS) begin
              if (cur_col != '0) cur_col <= cur_col - COL_W'(1);
            end else if (newline) begin
              cur_col <= '0;
              if (!last_row) begin
                cur_row <= cur_row + ROW_W'(1);
              end else begin
                // Both modes blank the physical row currently at the top.
                state   <= ST_CLEAR_ROW;
                clr_cnt <= '0;
                clr_row <= top;
                if (mode_scroll) top <= next_top;
                else             cur_row <= '0;
              end
            end else if (is_printable(rx_data)) begin
              cur_col <= cur_col + COL_W'(1);
            end
          end
        end
        ST_CLEAR_ROW: begin
          if (clr_cnt[COL_W-1:0] == COL_W'(COLS-1)) state <= ST_IDLE;
          else clr_cnt <= clr_cnt + ADDR_W'(1);
        end
        ST_CLEAR_ALL: begin
          if (clr_cnt == ADDR_W'(CELLS-1)) state <= ST_IDLE;
          else clr_cnt <= clr_cnt + ADDR_W'(1);
        end
        default: begin
          state   <= ST_CLEAR_ALL;
          clr_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_text_console_buffer.sv
// Directed bench for text_console_buffer at COLS=32, ROWS=4.
module tb_text_console_buffer;
  localparam int COLS = 32;
  localparam int ROWS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       mode_scroll;
  logic [1:0] rd_row;
  logic [4:0] rd_col;
  logic [7:0] rd_data;
  logic [1:0] cur_row;
  logic [4:0] cur_col;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  text_console_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mode_scroll(mode_scroll),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .overrun    (overrun)
  );

  task automatic read_cell(input int r, input int c, output logic [7:0] d);
    @(negedge clk);
    rd_row = 2'(r);
    rd_col = 5'(c);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!rx_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ready: rx_ready=%b after %0d cycles, want 1", rx_ready, n);
    end
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (!rx_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready(1000);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic setup_abcd();
    int n;
    send_byte(8'h0C);
    count_stall(n);
    for (int i = 0; i < 32; i++) send_byte(8'h61);
    for (int i = 0; i < 32; i++) send_byte(8'h62);
    for (int i = 0; i < 32; i++) send_byte(8'h63);
    for (int i = 0; i < 5; i++)  send_byte(8'h64);
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] d;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mode_scroll = 1'b1;
    rd_row = 2'd0; rd_col = 5'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_ready, overrun, cur_row, cur_col, rd_data} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b ovr=%b cur=(%0d,%0d) rd=%h, want 0 0 (0,0) 00",
               rx_ready, overrun, cur_row, cur_col, rd_data);
    end
    reset = 1'b0;
    count_stall(n);
    vectors++;
    if (n !== 128) begin
      miscompares++;
      $display("FAIL reset_stall: %0d cycles, want 128", n);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, d);
        vectors++;
        if (d !== 8'h20) begin
          miscompares++;
          $display("FAIL reset_cell(%0d,%0d): %h, want 20", r, c, d);
        end
      end
    vectors++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_cursor: (%0d,%0d), want (0,0)", cur_row, cur_col);
    end
  endtask

  task automatic test_print_bs();
    logic [7:0] d;
    send_byte(8'h41);
    send_byte(8'h42);
    vectors++;
    if (cur_row !== 2'd0 || cur_col !== 5'd2) begin
      miscompares++;
      $display("FAIL print_cursor: (%0d,%0d), want (0,2)", cur_row, cur_col);
    end
    read_cell(0, 0, d);
    vectors++;
    if (d !== 8'h41) begin miscompares++; $display("FAIL print_cell00: %h, want 41", d); end
    read_cell(0, 1, d);
    vectors++;
    if (d !== 8'h42) begin miscompares++; $display("FAIL print_cell01: %h, want 42", d); end
    send_byte(8'h08);
    vectors++;
    if (cur_row !== 2'd0 || cur_col !== 5'd1) begin
      miscompares++;
      $display("FAIL bs_cursor: (%0d,%0d), want (0,1)", cur_row, cur_col);
    end
    read_cell(0, 1, d);
    vectors++;
    if (d !== 8'h20) begin miscompares++; $display("FAIL bs_cell01: %h, want 20", d); end
    read_cell(0, 0, d);
    vectors++;
    if (d !== 8'h41) begin miscompares++; $display("FAIL bs_cell00: %h, want 41", d); end
    send_byte(8'h0D);
    vectors++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0) begin
      miscompares++;
      $display("FAIL cr_cursor: (%0d,%0d), want (0,0)", cur_row, cur_col);
    end
    send_byte(8'h08);
    vectors++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0) begin
      miscompares++;
      $display("FAIL bs_col0_cursor: (%0d,%0d), want (0,0)", cur_row, cur_col);
    end
    read_cell(0, 0, d);
    vectors++;
    if (d !== 8'h41) begin miscompares++; $display("FAIL bs_col0_cell00: %h, want 41", d); end
    send_byte(8'h01);
    vectors++;
    if (cur_col !== 5'd0 || overrun !== 1'b0 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ignored_byte: col=%0d ovr=%b ready=%b, want 0 0 1", cur_col, overrun, rx_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] d;
    send_byte(8'h0C);
    count_stall(n);
    vectors++;
    if (n !== 128) begin miscompares++; $display("FAIL ff_stall: %0d cycles, want 128", n); end
    for (int i = 0; i < 32; i++) begin
      rx_data = 8'h58;
      rx_valid = 1'b1;
      vectors++;
      if (rx_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: %b, want 1", i, rx_ready);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    vectors++;
    if (cur_row !== 2'd1 || cur_col !== 5'd0) begin
      miscompares++;
      $display("FAIL b2b_cursor: (%0d,%0d), want (1,0)", cur_row, cur_col);
    end
    for (int c = 0; c < COLS; c++) begin
      read_cell(0, c, d);
      vectors++;
      if (d !== 8'h58) begin miscompares++; $display("FAIL b2b_row0[%0d]: %h, want 58", c, d); end
    end
    read_cell(1, 0, d);
    vectors++;
    if (d !== 8'h20) begin miscompares++; $display("FAIL b2b_row1: %h, want 20", d); end
  endtask

  task automatic test_scroll();
    int n;
    logic [7:0] d, e;
    mode_scroll = 1'b1;
    setup_abcd();
    vectors++;
    if (cur_row !== 2'd3 || cur_col !== 5'd5) begin
      miscompares++;
      $display("FAIL scroll_setup_cursor: (%0d,%0d), want (3,5)", cur_row, cur_col);
    end
    send_byte(8'h0A);
    count_stall(n);
    vectors++;
    if (n !== 32) begin miscompares++; $display("FAIL scroll_stall: %0d cycles, want 32", n); end
    vectors++;
    if (cur_row !== 2'd3 || cur_col !== 5'd0) begin
      miscompares++;
      $display("FAIL scroll_cursor: (%0d,%0d), want (3,0)", cur_row, cur_col);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        e = (r == 0) ? 8'h62 : (r == 1) ? 8'h63 : (r == 2 && c < 5) ? 8'h64 : 8'h20;
        read_cell(r, c, d);
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL scroll_cell(%0d,%0d): %h, want %h", r, c, d, e); end
      end
    send_byte(8'h5A);
    read_cell(3, 0, d);
    vectors++;
    if (d !== 8'h5A) begin miscompares++; $display("FAIL scroll_write_bottom: %h, want 5a", d); end
    read_cell(0, 0, d);
    vectors++;
    if (d !== 8'h62) begin miscompares++; $display("FAIL scroll_top_after_write: %h, want 62", d); end
  endtask

  task automatic test_wrap();
    int n;
    logic [7:0] d, e;
    mode_scroll = 1'b0;
    setup_abcd();
    send_byte(8'h0A);
    count_stall(n);
    vectors++;
    if (n !== 32) begin miscompares++; $display("FAIL wrap_stall: %0d cycles, want 32", n); end
    vectors++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0) begin
      miscompares++;
      $display("FAIL wrap_cursor: (%0d,%0d), want (0,0)", cur_row, cur_col);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        e = (r == 1) ? 8'h62 : (r == 2) ? 8'h63 : (r == 3 && c < 5) ? 8'h64 : 8'h20;
        read_cell(r, c, d);
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL wrap_cell(%0d,%0d): %h, want %h", r, c, d, e); end
      end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_before: %b, want 0", overrun); end
    send_byte(8'h51);
    send_byte(8'h0C);
    rx_data = 8'h41;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: %b, want 1", overrun); end
    wait_ready(200);
    vectors++;
    if (cur_row !== 2'd0 || cur_col !== 5'd0 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_after: cur=(%0d,%0d) ovr=%b, want (0,0) 1", cur_row, cur_col, overrun);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, d);
        vectors++;
        if (d !== 8'h20) begin miscompares++; $display("FAIL overrun_cell(%0d,%0d): %h, want 20", r, c, d); end
      end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    send_byte(8'h52);
    send_byte(8'h0C);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (rx_ready !== 1'b0 || overrun !== 1'b0 || cur_row !== 2'd0 || cur_col !== 5'd0) begin
      miscompares++;
      $display("FAIL midclear_reset: ready=%b ovr=%b cur=(%0d,%0d), want 0 0 (0,0)",
               rx_ready, overrun, cur_row, cur_col);
    end
    reset = 1'b0;
    count_stall(n);
    vectors++;
    if (n !== 128) begin miscompares++; $display("FAIL midclear_stall: %0d cycles, want 128", n); end
  endtask

  initial begin
    test_reset();
    test_print_bs();
    test_back_to_back();
    test_scroll();
    test_wrap();
    test_overrun();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
